// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control encodings
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [3:0] jalOp = 4'b1101;
    localparam logic [3:0] jrOp  = 4'b1110;

    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - EX operand forwarding select for one source register
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [3:0] src_addr,
    input  logic [3:0] mem_dst_addr,
    input  logic       mem_we_rf,
    input  logic [3:0] wb_dst_addr,
    input  logic       wb_we_rf,
    output logic [1:0] fwd_sel
);

    // MEM is checked first because it holds the younger result
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_we_rf && (mem_dst_addr == src_addr)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_we_rf && (wb_dst_addr == src_addr)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, jump squash, halt drain and perf counters
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_p0_addr,
    input  logic [3:0]       id_p1_addr,
    input  logic             id_re0,
    input  logic             id_re1,
    input  logic             id_j_ctrl,
    input  logic             id_hlt,
    input  logic [3:0]       ex_dst_addr,
    input  logic             ex_we_rf,
    input  logic             ex_re_mem,
    input  logic [3:0]       ex_src0_addr,
    input  logic [3:0]       ex_src1_addr,
    input  logic [3:0]       mem_dst_addr,
    input  logic             mem_we_rf,
    input  logic [3:0]       wb_dst_addr,
    input  logic             wb_we_rf,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             j_take,
    output logic [1:0]       fwd0_sel,
    output logic [1:0]       fwd1_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    pipe_state_t   state, state_next;
    logic [DW-1:0] drain_cnt, drain_next;
    logic          lu;
    logic          hlt_acc;
    logic          running;

    assign lu = ex_re_mem & ex_we_rf &
                ((id_re0 & (id_p0_addr == ex_dst_addr)) |
                 (id_re1 & (id_p1_addr == ex_dst_addr)));

    assign running      = (state == ST_RUN);
    assign j_take       = id_j_ctrl & ~lu & running;
    assign stall_pc     = lu | hlt_acc | ~running;
    assign stall_if_id  = lu;
    assign bubble_id_ex = lu;
    assign flush_if_id  = j_take | hlt_acc | ~running;

    fwd_unit u_fwd0 (
        .src_addr     (ex_src0_addr),
        .mem_dst_addr (mem_dst_addr),
        .mem_we_rf    (mem_we_rf),
        .wb_dst_addr  (wb_dst_addr),
        .wb_we_rf     (wb_we_rf),
        .fwd_sel      (fwd0_sel)
    );

    fwd_unit u_fwd1 (
        .src_addr     (ex_src1_addr),
        .mem_dst_addr (mem_dst_addr),
        .mem_we_rf    (mem_we_rf),
        .wb_dst_addr  (wb_dst_addr),
        .wb_we_rf     (wb_we_rf),
        .fwd_sel      (fwd1_sel)
    );

    // A hlt stalled by a load-use hazard is accepted on the following cycle
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        hlt_acc    = 1'b0;
        case (state)
            ST_RUN: begin
                if (id_hlt && !lu) begin
                    hlt_acc    = 1'b1;
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = ST_HALTED;
                end else begin
                    drain_next = drain_cnt - DW'(1);
                end
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            halted    <= (state_next == ST_HALTED);
            if (running && lu && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (j_take && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a reference model
module tb_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int unsigned CMAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  id_p0_addr = '0, id_p1_addr = '0;
    logic        id_re0 = 1'b0, id_re1 = 1'b0, id_j_ctrl = 1'b0, id_hlt = 1'b0;
    logic [3:0]  ex_dst_addr = '0;
    logic        ex_we_rf = 1'b0, ex_re_mem = 1'b0;
    logic [3:0]  ex_src0_addr = '0, ex_src1_addr = '0;
    logic [3:0]  mem_dst_addr = '0;
    logic        mem_we_rf = 1'b0;
    logic [3:0]  wb_dst_addr = '0;
    logic        wb_we_rf = 1'b0;
    logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id, j_take, halted;
    logic [1:0]  fwd0_sel, fwd1_sel;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    int          m_age;
    int unsigned m_stall, m_flush;

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_p0_addr   (id_p0_addr),
        .id_p1_addr   (id_p1_addr),
        .id_re0       (id_re0),
        .id_re1       (id_re1),
        .id_j_ctrl    (id_j_ctrl),
        .id_hlt       (id_hlt),
        .ex_dst_addr  (ex_dst_addr),
        .ex_we_rf     (ex_we_rf),
        .ex_re_mem    (ex_re_mem),
        .ex_src0_addr (ex_src0_addr),
        .ex_src1_addr (ex_src1_addr),
        .mem_dst_addr (mem_dst_addr),
        .mem_we_rf    (mem_we_rf),
        .wb_dst_addr  (wb_dst_addr),
        .wb_we_rf     (wb_we_rf),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .j_take       (j_take),
        .fwd0_sel     (fwd0_sel),
        .fwd1_sel     (fwd1_sel),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [3:0] src);
        if (mem_we_rf && mem_dst_addr == src) return 2'b01;
        if (wb_we_rf && wb_dst_addr == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic drive_idle();
        {id_re0, id_re1, id_j_ctrl, id_hlt, ex_we_rf, ex_re_mem, mem_we_rf, wb_we_rf} = '0;
        {id_p0_addr, id_p1_addr, ex_dst_addr, ex_src0_addr} = '0;
        {ex_src1_addr, mem_dst_addr, wb_dst_addr} = '0;
    endtask

    task automatic model_reset();
        m_age   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Checks all outputs against the model, then advances the model across one edge
    task automatic step();
        logic lu_e, run_e, jt_e, hacc_e;
        #1;
        lu_e   = ex_re_mem && ex_we_rf &&
                 ((id_re0 && id_p0_addr == ex_dst_addr) || (id_re1 && id_p1_addr == ex_dst_addr));
        run_e  = (m_age == 0);
        jt_e   = id_j_ctrl && !lu_e && run_e;
        hacc_e = id_hlt && !lu_e && run_e;
        check("stall_pc",     stall_pc,     lu_e || hacc_e || !run_e);
        check("stall_if_id",  stall_if_id,  lu_e);
        check("bubble_id_ex", bubble_id_ex, lu_e);
        check("flush_if_id",  flush_if_id,  jt_e || hacc_e || !run_e);
        check("j_take",       j_take,       jt_e);
        check("fwd0_sel",     fwd0_sel,     fwd_ref(ex_src0_addr));
        check("fwd1_sel",     fwd1_sel,     fwd_ref(ex_src1_addr));
        check("halted",       halted,       m_age > DRAIN);
        check("stall_cnt",    stall_cnt,    m_stall);
        check("flush_cnt",    flush_cnt,    m_flush);
        @(posedge clk);
        if (run_e && lu_e && m_stall < CMAX) m_stall++;
        if (jt_e && m_flush < CMAX) m_flush++;
        if (hacc_e) m_age = 1;
        else if (m_age > 0 && m_age < 1000) m_age++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_halted",    halted,    1'b0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        check("rst_flush_cnt", flush_cnt, 16'd0);
        check("rst_stall_pc",  stall_pc,  1'b0);
        check("rst_flush",     flush_if_id, 1'b0);
        check("rst_fwd0",      fwd0_sel,  2'b00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_r(input logic [3:0] r);
        ex_re_mem = 1'b1;
        ex_we_rf = 1'b1;
        ex_dst_addr = r;
        id_re0 = 1'b1;
        id_p0_addr = r;
    endtask

    initial begin
        model_reset();
        do_reset();

        // load-use on R3
        @(negedge clk); drive_idle(); load_r(4'd3);
        #1 check("lu_stall", stall_pc, 1'b1);
        step();
        @(negedge clk); drive_idle();
        #1 check("lu_one_cycle", stall_if_id, 1'b0);
        check("lu_cnt", stall_cnt, 16'd1);
        step();

        // forwarding priority
        @(negedge clk); drive_idle();
        ex_src0_addr = 4'd5; mem_dst_addr = 4'd5; mem_we_rf = 1'b1; wb_dst_addr = 4'd5; wb_we_rf = 1'b1;
        #1 check("fwd_mem_wins", fwd0_sel, 2'b01);
        mem_we_rf = 1'b0;
        #1 check("fwd_wb", fwd0_sel, 2'b10);
        step();

        // jr behind a load of its source
        do_reset();
        @(negedge clk); drive_idle(); load_r(4'd2); id_j_ctrl = 1'b1;
        #1 check("jmp_held", j_take, 1'b0);
        step();
        @(negedge clk); drive_idle(); id_j_ctrl = 1'b1; id_re0 = 1'b1; id_p0_addr = 4'd2;
        #1 check("jmp_taken", j_take, 1'b1);
        check("jmp_flush", flush_if_id, 1'b1);
        step();
        @(negedge clk); drive_idle();
        #1 check("jmp_cnt", flush_cnt, 16'd1);
        step();

        // halt latency, jumps ignored while draining/halted
        do_reset();
        repeat (2) begin @(negedge clk); drive_idle(); step(); end
        @(negedge clk); drive_idle(); id_hlt = 1'b1;
        #1 check("hlt_stall_pc", stall_pc, 1'b1);
        step();
        for (int k = 1; k <= DRAIN + 1; k++) begin
            @(negedge clk); drive_idle(); id_j_ctrl = 1'b1;
            #1 check("hlt_latency", halted, (k == DRAIN + 1));
            check("hlt_no_jump", j_take, 1'b0);
            step();
        end

        // asynchronous reset in the middle of DRAIN
        do_reset();
        @(negedge clk); drive_idle(); id_hlt = 1'b1; step();
        @(negedge clk); drive_idle(); step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_halted", halted, 1'b0);
        check("mid_rst_run", stall_pc, 1'b0);
        check("mid_rst_flush_cnt", flush_cnt, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); drive_idle(); id_j_ctrl = 1'b1;
        #1 check("post_rst_jump", j_take, 1'b1);
        step();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            id_p0_addr   = 4'($urandom_range(0, 3));
            id_p1_addr   = 4'($urandom_range(0, 3));
            id_re0       = 1'($urandom);
            id_re1       = 1'($urandom);
            ex_dst_addr  = 4'($urandom_range(0, 3));
            ex_we_rf     = 1'($urandom);
            ex_re_mem    = 1'($urandom);
            ex_src0_addr = 4'($urandom_range(0, 3));
            ex_src1_addr = 4'($urandom_range(0, 3));
            mem_dst_addr = 4'($urandom_range(0, 3));
            mem_we_rf    = 1'($urandom);
            wb_dst_addr  = 4'($urandom_range(0, 3));
            wb_we_rf     = 1'($urandom);
            id_hlt       = ($urandom_range(0, 39) == 0);
            id_j_ctrl    = !id_hlt && ($urandom_range(0, 7) == 0);
            step();
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        // stall counter saturation
        do_reset();
        @(negedge clk); drive_idle(); load_r(4'd7);
        step();
        repeat (65533) @(posedge clk);
        m_stall = 65534;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            step();
        end
        @(negedge clk);
        #1 check("sat_hold", stall_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
